// File: rtl/fetch_queue_pkg.sv
// Types and constants shared by the IF/ID stages and the fetch queue between them.
package fetch_queue_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Occupancy classes of the queue; tracked as a registered state
   typedef enum logic [1:0] {
      StEmpty,
      StPartial,
      StFull
   } fq_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: IF push side, ID pop side, flush and occupancy.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_pc;
   logic [31:0]     in_inst;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_pc;
   logic [31:0]     out_inst;
   logic            flush;
   logic [CntW-1:0] count;

   // Pipeline side: drives fetched pairs, decode acceptance and redirects
   modport master (
      output in_valid, in_pc, in_inst, out_ready, flush,
      input  in_ready, out_valid, out_pc, out_inst, count
   );

   // Queue side
   modport slave (
      input  in_valid, in_pc, in_inst, out_ready, flush,
      output in_ready, out_valid, out_pc, out_inst, count
   );

endinterface

// File: rtl/fetch_queue.sv
// In-order decoupling queue of (PC, instruction) pairs between IF and ID.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave fq_io
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
   localparam logic [CntW-1:0] OneCnt  = CntW'(1);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   fq_state_e       state_q, state_d;

   logic push, pop;
   logic in_ready, out_valid;

   // Handshake outputs come from registered state only
   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);

   assign push = fq_io.in_valid & in_ready & ~fq_io.flush;
   assign pop  = out_valid & fq_io.out_ready & ~fq_io.flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (fq_io.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + OneCnt;
            2'b01:   cnt_d = cnt_q - OneCnt;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StEmpty:   if (push) state_d = StPartial;
         StPartial: begin
            if (push && !pop && cnt_q == FullCnt - OneCnt) begin
               state_d = StFull;
            end else if (pop && !push && cnt_q == OneCnt) begin
               state_d = StEmpty;
            end
         end
         StFull:    if (pop) state_d = StPartial;
         default:   state_d = StEmpty;
      endcase
      if (fq_io.flush) state_d = StEmpty;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= StEmpty;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= '{pc: fq_io.in_pc, inst: fq_io.in_inst};
      end
   end

   // Empty queue presents a NOP bubble at the reset vector
   always_comb begin
      fq_io.out_pc   = RESET_PC;
      fq_io.out_inst = NOP_INST;
      if (out_valid) begin
         fq_io.out_pc   = mem_q[rd_ptr_q].pc;
         fq_io.out_inst = mem_q[rd_ptr_q].inst;
      end
   end

   assign fq_io.in_ready  = in_ready;
   assign fq_io.out_valid = out_valid;
   assign fq_io.count     = cnt_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ordering, full/empty limits, wrap, flush, async reset.
module tb_fetch_queue;

   localparam logic [31:0] RV = 32'h0040_0000;

   logic clk = 1'b0;
   logic reset;
   int   n_asserts = 0;
   int   n_fail    = 0;

   fetch_queue_if #(.DEPTH(4)) fq ();

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (RV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .fq_io (fq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return ~pc ^ 32'h1357_9bdf;
   endfunction

   task automatic drive_push(input logic [31:0] pc);
      fq.in_valid = 1'b1;
      fq.in_pc    = pc;
      fq.in_inst  = inst_of(pc);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".in_ready"}, 32'(fq.in_ready), 32'd1);
      chk({tag, ".out_valid"}, 32'(fq.out_valid), 32'd0);
      chk({tag, ".out_pc"}, fq.out_pc, RV);
      chk({tag, ".out_inst"}, fq.out_inst, 32'h0);
      chk({tag, ".count"}, 32'(fq.count), 32'd0);
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, ".valid"}, 32'(fq.out_valid), 32'd1);
      chk({tag, ".pc"}, fq.out_pc, pc);
      chk({tag, ".inst"}, fq.out_inst, inst_of(pc));
   endtask

   initial begin
      reset        = 1'b1;
      fq.in_valid  = 1'b0;
      fq.in_pc     = '0;
      fq.in_inst   = '0;
      fq.out_ready = 1'b0;
      fq.flush     = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_idle("reset");

      // Three pushes with ID stalled, then drain in PC order
      for (int i = 0; i < 3; i++) begin
         drive_push(RV + 32'(4 * i));
         tick();
         if (i == 0) chk_head("latency", RV);
      end
      fq.in_valid = 1'b0;
      chk("fill3.count", 32'(fq.count), 32'd3);
      fq.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk_head("drain3", RV + 32'(4 * i));
         tick();
      end
      fq.out_ready = 1'b0;
      chk_idle("drain3.end");

      // Fill to DEPTH; a fifth offer must be refused
      for (int i = 0; i < 4; i++) begin
         drive_push(RV + 32'h10 + 32'(4 * i));
         tick();
      end
      chk("full.in_ready", 32'(fq.in_ready), 32'd0);
      chk("full.count", 32'(fq.count), 32'd4);
      drive_push(RV + 32'h20);
      tick();
      chk("full.hold.count", 32'(fq.count), 32'd4);
      chk_head("full.head", RV + 32'h10);
      // Pop while full: no push in the same cycle
      fq.out_ready = 1'b1;
      tick();
      fq.in_valid  = 1'b0;
      fq.out_ready = 1'b0;
      chk("full.pop.count", 32'(fq.count), 32'd3);
      chk("full.pop.in_ready", 32'(fq.in_ready), 32'd1);
      fq.out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         chk_head("full.drain", RV + 32'h10 + 32'(4 * i));
         tick();
      end
      fq.out_ready = 1'b0;
      chk_idle("full.drain.end");

      // Steady stream of 12 entries, one in and one out per cycle
      drive_push(RV);
      tick();
      fq.out_ready = 1'b1;
      for (int i = 1; i < 12; i++) begin
         drive_push(RV + 32'(4 * i));
         chk_head("stream", RV + 32'(4 * (i - 1)));
         tick();
         chk("stream.count", 32'(fq.count), 32'd1);
      end
      fq.in_valid = 1'b0;
      chk_head("stream.last", RV + 32'(4 * 11));
      tick();
      fq.out_ready = 1'b0;
      chk_idle("stream.end");

      // Flush with simultaneous push and pop drops everything
      for (int i = 0; i < 3; i++) begin
         drive_push(RV + 32'h40 + 32'(4 * i));
         tick();
      end
      chk("preflush.count", 32'(fq.count), 32'd3);
      drive_push(RV + 32'h100);
      fq.out_ready = 1'b1;
      fq.flush     = 1'b1;
      tick();
      fq.flush     = 1'b0;
      fq.out_ready = 1'b0;
      fq.in_valid  = 1'b0;
      chk_idle("flush");
      drive_push(RV + 32'h200);
      tick();
      fq.in_valid = 1'b0;
      chk_head("postflush", RV + 32'h200);
      chk("postflush.count", 32'(fq.count), 32'd1);
      fq.out_ready = 1'b1;
      tick();
      fq.out_ready = 1'b0;
      chk_idle("postflush.end");

      // Asynchronous reset mid-stream, checked before the next edge
      drive_push(RV + 32'h300);
      tick();
      drive_push(RV + 32'h304);
      tick();
      fq.in_valid = 1'b0;
      chk("prereset.count", 32'(fq.count), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk_idle("async_reset");
      #2;
      reset = 1'b0;
      tick();
      chk_idle("after_reset");
      drive_push(RV + 32'h400);
      tick();
      fq.in_valid = 1'b0;
      chk_head("after_reset.first", RV + 32'h400);
      chk("after_reset.count", 32'(fq.count), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
